// File: rtl/dmem_pkg.sv
// Shared types and encodings for the sized data memory.
package dmem_pkg;

  // Access size encodings carried on req_size.
  localparam logic [1:0] SZ_B    = 2'b00;
  localparam logic [1:0] SZ_H    = 2'b01;
  localparam logic [1:0] SZ_W    = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // INIT clears the array one word per cycle; RUN serves requests.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // One response as it travels down the latency pipeline.
  typedef struct packed {
    logic        valid;
    logic        fault;
    logic [31:0] rdata;
  } resp_t;

endpackage

// File: rtl/dmem_resp_pipe.sv
// LATENCY-deep response shift register; the last stage drives the port.
// An asynchronous clear drops every in-flight response at once.
module dmem_resp_pipe
  import dmem_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  resp_t resp_i,
  output resp_t resp_o
);

  resp_t stage_q [LATENCY];

  // Shift responses one stage per cycle; reset empties the pipe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LATENCY; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= resp_i;
      for (int i = 1; i < LATENCY; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign resp_o = stage_q[LATENCY-1];

endmodule

// File: rtl/dmem_sized.sv
// Byte/half/word data memory with fault detection and a fixed response latency.
// Handshake: a request is accepted on a rising edge where req_valid && req_ready;
// responses have no backpressure and appear in acceptance order.
// LATENCY must be 1..4 and MEM_BYTES a multiple of 4 (at least 4).
module dmem_sized
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 32,
  parameter int unsigned LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [7:0]  fault_count
);

  localparam int unsigned WORDS = MEM_BYTES / 4;
  localparam int unsigned IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   init_cnt_q, init_cnt_d;
  logic [31:0]     mem_q [WORDS];
  logic [7:0]      fault_count_q;

  logic            accept;
  logic            fault;
  logic            size_rsvd, misalign;
  logic [2:0]      nbytes;
  logic [32:0]     acc_end;
  logic [IW-1:0]   word_idx;
  logic [3:0]      wr_mask;
  logic [31:0]     wr_data;
  logic [31:0]     rd_word;
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;
  logic [31:0]     ld_data;
  resp_t           pipe_in, pipe_out;

  // State register and INIT word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Next state: sweep every word once, then serve requests until reset.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + IW'(1);
        if (init_cnt_q == LAST_IDX) begin
          state_d    = ST_RUN;
          init_cnt_d = '0;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  assign req_ready = (state_q == ST_RUN);
  assign accept    = req_valid && req_ready;
  assign word_idx  = req_addr[IW+1:2];

  // Decode size into byte count, alignment check and store lane steering.
  always_comb begin
    size_rsvd = 1'b0;
    misalign  = 1'b0;
    nbytes    = 3'd4;
    wr_mask   = 4'b0000;
    wr_data   = '0;
    case (req_size)
      SZ_B: begin
        nbytes  = 3'd1;
        wr_mask = 4'b0001 << req_addr[1:0];
        wr_data = {4{req_wdata[7:0]}};
      end
      SZ_H: begin
        nbytes   = 3'd2;
        misalign = req_addr[0];
        wr_mask  = req_addr[1] ? 4'b1100 : 4'b0011;
        wr_data  = {2{req_wdata[15:0]}};
      end
      SZ_W: begin
        nbytes   = 3'd4;
        misalign = |req_addr[1:0];
        wr_mask  = 4'b1111;
        wr_data  = req_wdata;
      end
      default: size_rsvd = 1'b1;
    endcase
  end

  // 33-bit end address so accesses near 0xFFFFFFFF cannot wrap into range.
  assign acc_end = {1'b0, req_addr} + {30'd0, nbytes};
  assign fault   = size_rsvd | misalign | (acc_end > 33'(MEM_BYTES));

  // Load path: pick the addressed lane and extend it to 32 bits.
  always_comb begin
    rd_word = mem_q[word_idx];
    rd_byte = rd_word[{req_addr[1:0], 3'b000} +: 8];
    rd_half = req_addr[1] ? rd_word[31:16] : rd_word[15:0];
    ld_data = '0;
    case (req_size)
      SZ_B:    ld_data = req_unsigned ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      SZ_H:    ld_data = req_unsigned ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
      SZ_W:    ld_data = rd_word;
      default: ld_data = '0;
    endcase
  end

  // Array write: zero sweep during INIT, lane-masked stores in RUN.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem_q[init_cnt_q] <= '0;
    end else if (accept && req_we && !fault) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) mem_q[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Saturating count of accepted requests that faulted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_count_q <= '0;
    end else if (accept && fault && (fault_count_q != 8'hFF)) begin
      fault_count_q <= fault_count_q + 8'd1;
    end
  end

  assign fault_count = fault_count_q;

  // Read data is captured at the accept edge, so stores only return zero.
  always_comb begin
    pipe_in       = '0;
    pipe_in.valid = accept;
    pipe_in.fault = accept && fault;
    pipe_in.rdata = (accept && !req_we && !fault) ? ld_data : 32'd0;
  end

  dmem_resp_pipe #(.LATENCY(LATENCY)) u_resp_pipe (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .resp_i (pipe_in),
    .resp_o (pipe_out)
  );

  assign resp_valid = pipe_out.valid;
  assign resp_fault = pipe_out.fault;
  assign resp_rdata = pipe_out.rdata;

endmodule

// File: tb/tb_dmem_sized.sv
// Directed bench for dmem_sized (MEM_BYTES=32, LATENCY=2) with a response scoreboard.
module tb_dmem_sized;

  localparam int unsigned MEM_BYTES = 32;
  localparam int unsigned LATENCY   = 2;

  localparam logic [1:0] B = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] W = 2'b10;
  localparam logic [1:0] R = 2'b11;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [7:0]  fault_count;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Expected {fault, rdata}, accept cycle and label per accepted request.
  logic [32:0] exp_q[$];
  int          acc_q[$];
  string       lbl_q[$];

  dmem_sized #(.MEM_BYTES(MEM_BYTES), .LATENCY(LATENCY)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_fault   (resp_fault),
    .fault_count  (fault_count)
  );

  // Clock and cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare whenever the DUT presents a response.
  logic [32:0] mon_e;
  int          mon_a;
  string       mon_l;
  always @(negedge clk) begin
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_resp: got response fault=%0b rdata=0x%08h, expected none",
                 resp_fault, resp_rdata);
      end else begin
        mon_e = exp_q.pop_front();
        mon_a = acc_q.pop_front();
        mon_l = lbl_q.pop_front();
        check({mon_l, "_fault"}, {31'd0, resp_fault}, {31'd0, mon_e[32]});
        check({mon_l, "_rdata"}, resp_rdata, mon_e[31:0]);
        check({mon_l, "_latency"}, 32'(cyc - mon_a), 32'(LATENCY - 1));
      end
    end
  end

  // Driver: present one request for one edge and record its expected response.
  task automatic issue(input string lbl, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic ef, input logic [31:0] er);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(posedge clk);
    #1;
    exp_q.push_back({ef, er});
    acc_q.push_back(cyc);
    lbl_q.push_back(lbl);
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d responses outstanding, expected 0", exp_q.size());
      exp_q.delete();
      acc_q.delete();
      lbl_q.delete();
    end
  endtask

  // Count edges from reset release until req_ready rises.
  task automatic wait_init(input string name);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!req_ready && n < 50);
    check(name, 32'(n), 32'(MEM_BYTES / 4));
  endtask

  // Directed scenarios
  initial begin
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = W;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    #1;
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_fault", {31'd0, resp_fault}, 32'd0);
    check("rst_fcount", {24'd0, fault_count}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init("init_len");

    // 1: fresh memory reads zero
    issue("lw_00", 1'b0, W, 1'b0, 32'h00, 32'h0, 1'b0, 32'h0000_0000);
    drain();

    // 2: word store then sized loads
    issue("sw_04",   1'b1, W, 1'b0, 32'h04, 32'hDEAD_BEEF, 1'b0, 32'h0);
    issue("lb_07",   1'b0, B, 1'b0, 32'h07, 32'h0, 1'b0, 32'hFFFF_FFDE);
    issue("lbu_07",  1'b0, B, 1'b1, 32'h07, 32'h0, 1'b0, 32'h0000_00DE);
    issue("lh_04",   1'b0, H, 1'b0, 32'h04, 32'h0, 1'b0, 32'hFFFF_BEEF);
    issue("lhu_06",  1'b0, H, 1'b1, 32'h06, 32'h0, 1'b0, 32'h0000_DEAD);

    // 3: byte store touches one lane only
    issue("sb_05",   1'b1, B, 1'b0, 32'h05, 32'h0000_0055, 1'b0, 32'h0);
    issue("lw_04",   1'b0, W, 1'b0, 32'h04, 32'h0, 1'b0, 32'hDEAD_55EF);
    issue("lb_04",   1'b0, B, 1'b0, 32'h04, 32'h0, 1'b0, 32'hFFFF_FFEF);
    issue("lhu_04",  1'b0, H, 1'b1, 32'h04, 32'h0, 1'b0, 32'h0000_55EF);
    issue("lwu_04",  1'b0, W, 1'b1, 32'h04, 32'h0, 1'b0, 32'hDEAD_55EF);
    issue("sh_0a",   1'b1, H, 1'b0, 32'h0A, 32'hFFFF_1234, 1'b0, 32'h0);
    issue("lw_08",   1'b0, W, 1'b0, 32'h08, 32'h0, 1'b0, 32'h1234_0000);
    drain();

    // 4: faults
    issue("lw_05_mis",  1'b0, W, 1'b0, 32'h05, 32'h0, 1'b1, 32'h0);
    issue("sw_20_oor",  1'b1, W, 1'b0, 32'h20, 32'h1234_5678, 1'b1, 32'h0);
    issue("rsvd_00",    1'b0, R, 1'b0, 32'h00, 32'h0, 1'b1, 32'h0);
    check("fcount_3", {24'd0, fault_count}, 32'd3);
    issue("lw_1c",      1'b0, W, 1'b0, 32'h1C, 32'h0, 1'b0, 32'h0);
    issue("lw_00_nowrap", 1'b0, W, 1'b0, 32'h00, 32'h0, 1'b0, 32'h0);
    issue("sh_09_mis",  1'b1, H, 1'b0, 32'h09, 32'h0000_9999, 1'b1, 32'h0);
    issue("lw_08_kept", 1'b0, W, 1'b0, 32'h08, 32'h0, 1'b0, 32'h1234_0000);
    drain();

    // 5: back-to-back store/load at the top of memory
    issue("sw_1c",     1'b1, W, 1'b0, 32'h1C, 32'hAABB_CCDD, 1'b0, 32'h0);
    issue("lw_1c_b2b", 1'b0, W, 1'b0, 32'h1C, 32'h0, 1'b0, 32'hAABB_CCDD);
    issue("lh_1e",     1'b0, H, 1'b0, 32'h1E, 32'h0, 1'b0, 32'hFFFF_AABB);
    issue("lh_1f_mis", 1'b0, H, 1'b0, 32'h1F, 32'h0, 1'b1, 32'h0);
    issue("lb_1f",     1'b0, B, 1'b0, 32'h1F, 32'h0, 1'b0, 32'hFFFF_FFAA);
    issue("lb_20_oor", 1'b0, B, 1'b0, 32'h20, 32'h0, 1'b1, 32'h0);
    issue("lw_top_oor", 1'b0, W, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'h0);
    drain();
    check("fcount_7", {24'd0, fault_count}, 32'd7);

    // 6: reset with responses in flight
    issue("inflight_a", 1'b0, W, 1'b0, 32'h1C, 32'h0, 1'b0, 32'hAABB_CCDD);
    issue("inflight_b", 1'b0, W, 1'b0, 32'h04, 32'h0, 1'b0, 32'hDEAD_55EF);
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    lbl_q.delete();
    #1;
    check("midrst_valid", {31'd0, resp_valid}, 32'd0);
    check("midrst_fcount", {24'd0, fault_count}, 32'd0);
    check("midrst_ready", {31'd0, req_ready}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init("reinit_len");
    issue("lw_04_clr", 1'b0, W, 1'b0, 32'h04, 32'h0, 1'b0, 32'h0);
    issue("lw_1c_clr", 1'b0, W, 1'b0, 32'h1C, 32'h0, 1'b0, 32'h0);
    drain();
    idle(3);
    check("final_fcount", {24'd0, fault_count}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "timeout");
  end

endmodule
